game_round_sequencer: RTL and testbench

Round/level controller for the ball-maze game. It owns the game flow: title screen, level load, play with a frame-count time limit, victory hold, timeout, and game complete. It feeds the physics/render block a per-level map select plus spawn and finish coordinates, a physics enable, and screen-select flags. It consumes that block's victory level and the centre button, and advances state on the per-frame `end_of_frame` pulse.

---
 rtl/game_round_sequencer.sv | 179 +++++++++++++++++
 tb/tb_game_round_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// Round/level controller for the ball-maze game: title, level load, timed play, win hold, timeout, done.
// Optional pause in PLAY is enabled by defining GAME_SEQ_PAUSE_EN.
module game_round_sequencer #(
  parameter int NUM_LEVELS        = 2,
  parameter int LEVEL_TIME_FRAMES = 3600,
  parameter int WIN_HOLD_FRAMES   = 180,
  parameter int DEBOUNCE_FRAMES   = 3
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        end_of_frame,
  input  logic        button_c,
  input  logic        victory_in,
  output logic        level_reset,
  output logic        physics_en,
  output logic [1:0]  map_sel,
  output logic [9:0]  ball_start_x,
  output logic [9:0]  ball_start_y,
  output logic [9:0]  finish_x,
  output logic [9:0]  finish_y,
  output logic        show_title,
  output logic        show_victory,
  output logic        show_timeout,
  output logic [11:0] time_left,
  output logic [2:0]  state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HW = (WIN_HOLD_FRAMES < 2) ? 1 : $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_FRAMES);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(WIN_HOLD_FRAMES);
  localparam logic [11:0]   TIME_INIT  = 12'(LEVEL_TIME_FRAMES);
  localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4,
`ifdef GAME_SEQ_PAUSE_EN
    DONE  = 3'd5,
    PAUSE = 3'd6
`else
    DONE  = 3'd5
`endif
  } state_e;

  logic          btn_meta_q, btn_sync_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_q, press_d;
  state_e        state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic [11:0]   time_q, time_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_reset_q, physics_en_q, show_title_q, show_victory_q, show_timeout_q;

  // Counter saturates at DEBOUNCE_FRAMES, so a held button yields one press until released.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    if (end_of_frame) begin
      if (btn_sync_q) begin
        if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + 1'b1;
        press_d = (deb_cnt_q == DEB_MAX - 1'b1);
      end else begin
        deb_cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    time_d  = time_q;
    hold_d  = hold_q;
    case (state_q)
      TITLE: if (press_q) begin
        level_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        time_d  = TIME_INIT;
        state_d = PLAY;
      end
      PLAY: begin
`ifdef GAME_SEQ_PAUSE_EN
        if (press_q) state_d = PAUSE;
        else
`endif
        if (end_of_frame) begin
          if (victory_in) begin
            hold_d  = HOLD_INIT;
            state_d = WIN;
          end else if (time_q == 12'd1) begin
            time_d  = '0;
            state_d = LOSE;
          end else if (time_q != '0) begin
            time_d = time_q - 1'b1;
          end
        end
      end
      WIN: begin
        if (press_q || (end_of_frame && hold_q <= HW'(1))) begin
          hold_d = '0;
          if (level_q == LAST_LEVEL) begin
            state_d = DONE;
          end else begin
            level_d = level_q + 1'b1;
            state_d = LOAD;
          end
        end else if (end_of_frame && hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
      end
      LOSE: if (press_q) state_d = LOAD;
      DONE: if (press_q) begin
        level_d = '0;
        state_d = TITLE;
      end
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE: if (press_q) state_d = PLAY;
`endif
      default: state_d = TITLE;
    endcase
  end

  // Flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      btn_meta_q     <= 1'b0;
      btn_sync_q     <= 1'b0;
      deb_cnt_q      <= '0;
      press_q        <= 1'b0;
      state_q        <= TITLE;
      level_q        <= '0;
      time_q         <= '0;
      hold_q         <= '0;
      level_reset_q  <= 1'b0;
      physics_en_q   <= 1'b0;
      show_title_q   <= 1'b1;
      show_victory_q <= 1'b0;
      show_timeout_q <= 1'b0;
    end else begin
      btn_meta_q     <= button_c;
      btn_sync_q     <= btn_meta_q;
      deb_cnt_q      <= deb_cnt_d;
      press_q        <= press_d;
      state_q        <= state_d;
      level_q        <= level_d;
      time_q         <= time_d;
      hold_q         <= hold_d;
      level_reset_q  <= (state_d == LOAD);
      physics_en_q   <= (state_d == PLAY);
      show_title_q   <= (state_d == TITLE);
      show_victory_q <= (state_d == WIN) || (state_d == DONE);
      show_timeout_q <= (state_d == LOSE);
    end
  end

  always_comb begin
    case (level_q)
      2'd0: begin ball_start_x = 10'd400; ball_start_y = 10'd300; finish_x = 10'd600; finish_y = 10'd400; end
      2'd1: begin ball_start_x = 10'd100; ball_start_y = 10'd100; finish_x = 10'd700; finish_y = 10'd500; end
      2'd2: begin ball_start_x = 10'd700; ball_start_y = 10'd100; finish_x = 10'd100; finish_y = 10'd500; end
      default: begin ball_start_x = 10'd400; ball_start_y = 10'd500; finish_x = 10'd400; finish_y = 10'd100; end
    endcase
  end

  assign level_reset  = level_reset_q;
  assign physics_en   = physics_en_q;
  assign map_sel      = level_q;
  assign show_title   = show_title_q;
  assign show_victory = show_victory_q;
  assign show_timeout = show_timeout_q;
  assign time_left    = time_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: directed flow plus a table of win/level vectors.
// Covers the GAME_SEQ_PAUSE_EN build when that macro is defined.
module tb_game_round_sequencer;

`ifdef GAME_SEQ_PAUSE_EN
  localparam int LTF = 105;
`else
  localparam int LTF = 5;
`endif
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst_n, eof, button, victory;
  logic        level_reset, physics_en, show_title, show_victory, show_timeout;
  logic [1:0]  map_sel;
  logic [9:0]  bx, by, fx, fy;
  logic [11:0] time_left;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  game_round_sequencer #(
    .NUM_LEVELS(2), .LEVEL_TIME_FRAMES(LTF), .WIN_HOLD_FRAMES(4), .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .pixel_clk(clk), .rst_n(rst_n), .end_of_frame(eof), .button_c(button), .victory_in(victory),
    .level_reset(level_reset), .physics_en(physics_en), .map_sel(map_sel),
    .ball_start_x(bx), .ball_start_y(by), .finish_x(fx), .finish_y(fy),
    .show_title(show_title), .show_victory(show_victory), .show_timeout(show_timeout),
    .time_left(time_left), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (level_reset) pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit vic;
    int st, map, bx, by, fx, fy, tl;
    bit phys, vict;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    eof = 1'b1;
    @(posedge clk); #1;
    eof = 1'b0;
    idle(3);
  endtask

  task automatic hold_press();
    button = 1'b1;
    idle(2);
    repeat (DEB) frame();
    button = 1'b0;
    idle(2);
  endtask

  initial begin
    int exp_time, p0, found, exp_st;
    tbl[0] = '{0, 3, 0, 400, 300, 600, 400, 1,   0, 1};
    tbl[1] = '{0, 3, 0, 400, 300, 600, 400, 1,   0, 1};
    tbl[2] = '{0, 3, 0, 400, 300, 600, 400, 1,   0, 1};
    tbl[3] = '{0, 2, 1, 100, 100, 700, 500, LTF, 1, 0};
    tbl[4] = '{1, 3, 1, 100, 100, 700, 500, LTF, 0, 1};
    tbl[5] = '{0, 3, 1, 100, 100, 700, 500, LTF, 0, 1};
    tbl[6] = '{0, 3, 1, 100, 100, 700, 500, LTF, 0, 1};
    tbl[7] = '{0, 3, 1, 100, 100, 700, 500, LTF, 0, 1};
    tbl[8] = '{0, 5, 1, 100, 100, 700, 500, LTF, 0, 1};

    rst_n = 1'b0; eof = 1'b0; button = 1'b0; victory = 1'b0;
    idle(3);
    check("rst_state", state_dbg, 0);
    check("rst_title", show_title, 1);
    check("rst_phys", physics_en, 0);
    check("rst_lreset", level_reset, 0);
    check("rst_victory", show_victory, 0);
    check("rst_timeout", show_timeout, 0);
    check("rst_time", time_left, 0);
    check("rst_map", map_sel, 0);
    rst_n = 1'b1;
    idle(1);

    // First press from TITLE, cycle-accurate around the level_reset pulse
    button = 1'b1;
    idle(2);
    frame();
    frame();
    eof = 1'b1;
    @(posedge clk); #1;
    eof = 1'b0;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      @(negedge clk);
      if (level_reset) found = 1;
    end
    check("press_to_load", found, 1);
    if (found == 1) begin
      check("load_map", map_sel, 0);
      check("load_bx", bx, 400);
      check("load_by", by, 300);
      check("load_fx", fx, 600);
      check("load_fy", fy, 400);
      check("load_phys", physics_en, 0);
      @(negedge clk);
      check("play_phys", physics_en, 1);
      check("play_lreset", level_reset, 0);
      check("play_state", state_dbg, 2);
    end
    @(posedge clk); #1;
    button = 1'b0;
    idle(3);
    check("first_pulses", pulses, 1);
    check("first_time", time_left, LTF);
    exp_time = LTF;

`ifdef GAME_SEQ_PAUSE_EN
    frame();
    frame();
    exp_time = LTF - 2;
    check("pre_pause_time", time_left, exp_time);
    hold_press();
    exp_time = 100;
    check("pause_state", state_dbg, 6);
    check("pause_time", time_left, exp_time);
    check("pause_phys", physics_en, 0);
    victory = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("pause_f%0d_time", i), time_left, 100);
      check($sformatf("pause_f%0d_phys", i), physics_en, 0);
      check($sformatf("pause_f%0d_state", i), state_dbg, 6);
    end
    victory = 1'b0;
    p0 = pulses;
    hold_press();
    check("resume_state", state_dbg, 2);
    check("resume_phys", physics_en, 1);
    check("resume_time", time_left, 100);
    check("resume_no_pulse", pulses, p0);
    frame();
    exp_time = 99;
    check("resume_next_time", time_left, exp_time);
`else
    hold_press();
    exp_time = LTF - DEB;
    check("play_press_state", state_dbg, 2);
    check("play_press_phys", physics_en, 1);
    check("play_press_time", time_left, exp_time);
`endif

    while (exp_time > 0) begin
      frame();
      exp_time--;
      check("countdown_time", time_left, exp_time);
      if (exp_time > 0) check("countdown_state", state_dbg, 2);
    end
    check("lose_state", state_dbg, 4);
    check("lose_timeout", show_timeout, 1);
    check("lose_phys", physics_en, 0);

    p0 = pulses;
    hold_press();
    check("retry_pulses", pulses, p0 + 1);
    check("retry_map", map_sel, 0);
    check("retry_state", state_dbg, 2);
    check("retry_time", time_left, LTF);

    // Victory on the frame where time_left is 1 must win
    repeat (LTF - 1) frame();
    check("coinc_pre_time", time_left, 1);
    victory = 1'b1;
    frame();
    victory = 1'b0;
    check("coinc_state", state_dbg, 3);
    check("coinc_victory", show_victory, 1);
    check("coinc_timeout", show_timeout, 0);

    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      victory = tbl[i].vic;
      frame();
      victory = 1'b0;
      check($sformatf("row%0d_state", i), state_dbg, tbl[i].st);
      check($sformatf("row%0d_map", i), map_sel, tbl[i].map);
      check($sformatf("row%0d_bx", i), bx, tbl[i].bx);
      check($sformatf("row%0d_by", i), by, tbl[i].by);
      check($sformatf("row%0d_fx", i), fx, tbl[i].fx);
      check($sformatf("row%0d_fy", i), fy, tbl[i].fy);
      check($sformatf("row%0d_time", i), time_left, tbl[i].tl);
      check($sformatf("row%0d_phys", i), physics_en, tbl[i].phys);
      check($sformatf("row%0d_vict", i), show_victory, tbl[i].vict);
    end
    check("table_pulses", pulses, p0 + 1);

    p0 = pulses;
    hold_press();
    check("done_state", state_dbg, 0);
    check("done_title", show_title, 1);
    check("done_map", map_sel, 0);
    check("done_victory", show_victory, 0);
    check("done_pulses", pulses, p0);
    frame();

    // Bounce: two short bursts never reach the debounce count
    button = 1'b1; idle(2); frame(); frame();
    button = 1'b0; idle(2); frame();
    button = 1'b1; idle(2); frame(); frame();
    button = 1'b0; idle(2); frame();
    check("bounce_state", state_dbg, 0);
    check("bounce_pulses", pulses, p0);

    // Long hold gives exactly one press
    button = 1'b1;
    idle(2);
    repeat (20) frame();
    button = 1'b0;
    idle(2);
    exp_st = (LTF > 17) ? 2 : 4;
    exp_time = (LTF > 17) ? LTF - 17 : 0;
    check("hold_pulses", pulses, p0 + 1);
    check("hold_state", state_dbg, exp_st);
    check("hold_time", time_left, exp_time);

    rst_n = 1'b0;
    idle(1);
    check("midrst_state", state_dbg, 0);
    check("midrst_time", time_left, 0);
    check("midrst_title", show_title, 1);
    check("midrst_timeout", show_timeout, 0);
    check("midrst_phys", physics_en, 0);
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
